// File: rtl/stage_memory_lsu.sv
// MEM-stage load/store unit for the 5-stage rv32i pipeline.
// Issues one data-memory request per load/store, holds it until the response
// arrives (or an optional timeout expires), and returns the aligned and
// sign/zero-extended load result. The pipeline is stalled while a request is
// in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_in, is_load,  MEM-stage instruction; if both is_load and is_store
//   is_store, funct3    are set, the op is treated as a store
//   addr, store_data    effective address and rs2 value
//   dmem_read/write     request strobes, held until dmem_resp
//   dmem_address        word-aligned address
//   dmem_wdata/mbe      lane-shifted store data and byte enables
//   dmem_resp/rdata     one-cycle response pulse and read data
//   stall               freeze MEM and everything upstream
//   load_data/valid     load result, valid for one cycle
//   mem_err             misaligned, illegal funct3 or timeout (one-cycle pulse)
module stage_memory_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] busy_cnt;
  logic             req_load;
  logic [2:0]       req_funct3;
  logic [1:0]       req_off;

  logic             mem_op;
  logic             op_store;
  logic             f3_ok;
  logic             aligned;
  logic             op_legal;
  logic             timeout_hit;
  logic [3:0]       mbe_next;
  logic [XLEN-1:0]  wdata_next;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [XLEN-1:0]  load_ext;

  // Request decode and legality for the op presented in IDLE.
  always_comb begin
    mem_op   = valid_in & (is_load | is_store);
    op_store = is_store;

    if (op_store) begin
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end

    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    op_legal = mem_op & f3_ok & aligned;

    // Loads always fetch the whole word; the lane is picked on return.
    mbe_next = 4'b1111;
    if (op_store) begin
      case (funct3[1:0])
        2'b00:   mbe_next = 4'b0001 << addr[1:0];
        2'b01:   mbe_next = 4'b0011 << addr[1:0];
        default: mbe_next = 4'b1111;
      endcase
    end

    wdata_next = store_data << {addr[1:0], 3'b000};
  end

  // Stall rises in the same cycle a legal op arrives so the instruction is held.
  always_comb begin
    stall = (state == BUSY) || ((state == IDLE) && op_legal);
  end

  always_comb begin
    timeout_hit = TIMEOUT_EN && (busy_cnt == TIMEOUT_LAST);
  end

  // Lane extraction from the returned word using the captured offset.
  always_comb begin
    rd_byte = dmem_rdata[{req_off, 3'b000} +: 8];
    rd_half = dmem_rdata[{req_off[1], 4'b0000} +: 16];
    case (req_funct3)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  // FSM with registered memory-side and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy_cnt     <= '0;
      req_load     <= 1'b0;
      req_funct3   <= 3'b000;
      req_off      <= 2'b00;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_address <= '0;
      dmem_wdata   <= '0;
      dmem_mbe     <= 4'b0000;
      load_data    <= '0;
      load_valid   <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      mem_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (op_legal) begin
            state        <= BUSY;
            busy_cnt     <= '0;
            req_load     <= ~op_store;
            req_funct3   <= funct3;
            req_off      <= addr[1:0];
            dmem_read    <= ~op_store;
            dmem_write   <= op_store;
            dmem_address <= {addr[31:2], 2'b00};
            dmem_wdata   <= op_store ? wdata_next : '0;
            dmem_mbe     <= mbe_next;
          end else if (mem_op) begin
            mem_err <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (req_load) begin
              load_data  <= load_ext;
              load_valid <= 1'b1;
            end
            state <= DONE;
          end else if (timeout_hit) begin
            // Abandon the request; a load still retires, with a zero result.
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            mem_err    <= 1'b1;
            load_data  <= '0;
            load_valid <= req_load;
            state      <= DONE;
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory_lsu.sv
// Scoreboard bench for stage_memory_lsu: stimulus pushes expected requests and
// responses into queues; a monitor pops and compares whenever the DUT shows a
// request or a load_valid/mem_err pulse.
module tb_stage_memory_lsu;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        mem_err;

  stage_memory_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .is_load      (is_load),
    .is_store     (is_store),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_mbe     (dmem_mbe),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  mbe;
    bit          chk_wd;
  } req_t;

  typedef struct {
    logic        lv;
    logic        err;
    logic [31:0] data;
    bit          chk_data;
  } resp_t;

  req_t  exp_req_q[$];
  resp_t exp_resp_q[$];
  req_t  cur_req;
  resp_t cur_resp;
  bit    prev_req;

  int checks;
  int errors;
  int stall_cnt;
  int read_cnt;
  int write_cnt;
  int lv_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    stall_cnt = 0;
    read_cnt  = 0;
    write_cnt = 0;
    lv_cnt    = 0;
  endtask

  // Monitor: observes at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      stall_cnt += int'(stall);
      read_cnt  += int'(dmem_read);
      write_cnt += int'(dmem_write);
      lv_cnt    += int'(load_valid);

      if (load_valid || mem_err) begin
        if (exp_resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: load_valid=%0b mem_err=%0b load_data=0x%08h, none expected",
                   load_valid, mem_err, load_data);
        end else begin
          cur_resp = exp_resp_q.pop_front();
          check("load_valid", 32'(load_valid), 32'(cur_resp.lv));
          check("mem_err", 32'(mem_err), 32'(cur_resp.err));
          if (cur_resp.chk_data) check("load_data", load_data, cur_resp.data);
        end
      end

      if (dmem_read || dmem_write) begin
        check("rd_wr_exclusive", 32'(dmem_read & dmem_write), 32'd0);
        if (!prev_req) begin
          if (exp_req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: read=%0b write=%0b addr=0x%08h, none expected",
                     dmem_read, dmem_write, dmem_address);
            cur_req = '{dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe, 1'b0};
          end else begin
            cur_req = exp_req_q.pop_front();
          end
        end
        check("dmem_read", 32'(dmem_read), 32'(cur_req.rd));
        check("dmem_write", 32'(dmem_write), 32'(cur_req.wr));
        check("dmem_address", dmem_address, cur_req.adr);
        check("dmem_mbe", 32'(dmem_mbe), 32'(cur_req.mbe));
        if (cur_req.chk_wd) check("dmem_wdata", dmem_wdata, cur_req.wd);
      end
      prev_req = dmem_read || dmem_write;
    end
  end

  // Presents one instruction, holds it while stalled (as the pipeline would),
  // answers in BUSY cycle wait_n when respond is set, and returns one cycle
  // after retirement with the inputs cleared.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int wait_n, input logic [31:0] rd, input bit respond);
    int guard;
    int b;
    guard      = 0;
    b          = 0;
    valid_in   = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    dmem_resp  = 1'b0;
    #1;
    while (stall && guard < 100) begin
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      guard++;
      #1;
      if (stall) begin
        dmem_resp  = respond && (b == wait_n);
        dmem_rdata = rd;
        b++;
      end
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL op_bound: stall still high after %0d cycles, expected release", guard);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    prev_req   = 1'b0;
    rst        = 1'b1;
    valid_in   = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_read", 32'(dmem_read), 32'd0);
    check("rst_write", 32'(dmem_write), 32'd0);
    check("rst_mbe", 32'(dmem_mbe), 32'd0);
    check("rst_address", dmem_address, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_flags", 32'({load_valid, mem_err}), 32'd0);

    // lb from byte 3, sign-extended
    clr_cnt();
    exp_req_q.push_back('{1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'b1111, 1'b0});
    exp_resp_q.push_back('{1'b1, 1'b0, 32'hFFFF_FF80, 1'b1});
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234, 1'b1);
    check("lb_stall_cycles", stall_cnt, 32'd2);
    check("lb_read_cycles", read_cnt, 32'd1);
    check("lb_lv_cycles", lv_cnt, 32'd1);

    // sh to upper half with 4 wait cycles
    clr_cnt();
    exp_req_q.push_back('{1'b0, 1'b1, 32'h0000_2000, 32'hBEEF_0000, 4'b1100, 1'b1});
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 4, 32'h0, 1'b1);
    check("sh_write_cycles", write_cnt, 32'd5);
    check("sh_read_cycles", read_cnt, 32'd0);
    check("sh_stall_cycles", stall_cnt, 32'd6);
    check("sh_lv_cycles", lv_cnt, 32'd0);

    // sb to byte 3
    clr_cnt();
    exp_req_q.push_back('{1'b0, 1'b1, 32'h0000_1234, 32'hA500_0000, 4'b1000, 1'b1});
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_1237, 32'h0000_00A5, 0, 32'h0, 1'b1);
    check("sb_write_cycles", write_cnt, 32'd1);

    // Illegal store funct3
    clr_cnt();
    exp_resp_q.push_back('{1'b0, 1'b1, 32'h0, 1'b0});
    run_op(1'b0, 1'b1, 3'b100, 32'h0000_3000, 32'h1, 0, 32'h0, 1'b0);
    check("bad_st_stall", stall_cnt, 32'd0);
    check("bad_st_write", write_cnt, 32'd0);

    // Misaligned lw
    clr_cnt();
    exp_resp_q.push_back('{1'b0, 1'b1, 32'h0, 1'b0});
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 32'h0, 1'b0);
    check("mis_lw_stall", stall_cnt, 32'd0);
    check("mis_lw_read", read_cnt, 32'd0);

    // Illegal load funct3
    clr_cnt();
    exp_resp_q.push_back('{1'b0, 1'b1, 32'h0, 1'b0});
    run_op(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 32'h0, 1'b0);
    check("bad_ld_read", read_cnt, 32'd0);

    // lhu upper half, zero-extended
    exp_req_q.push_back('{1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'b1111, 1'b0});
    exp_resp_q.push_back('{1'b1, 1'b0, 32'h0000_ABCD, 1'b1});
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0, 0, 32'hABCD_0000, 1'b1);

    // lh upper half, sign-extended
    exp_req_q.push_back('{1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'b1111, 1'b0});
    exp_resp_q.push_back('{1'b1, 1'b0, 32'hFFFF_8001, 1'b1});
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_8002, 32'h0, 1, 32'h8001_1234, 1'b1);

    // Timeout: no response ever
    clr_cnt();
    exp_req_q.push_back('{1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'b1111, 1'b0});
    exp_resp_q.push_back('{1'b1, 1'b1, 32'h0, 1'b1});
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 0, 32'h0, 1'b0);
    check("to_read_cycles", read_cnt, 32'd8);
    check("to_stall_cycles", stall_cnt, 32'd9);

    // Reset during BUSY, then a late response
    clr_cnt();
    exp_req_q.push_back('{1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'b1111, 1'b0});
    valid_in = 1'b1;
    is_load  = 1'b1;
    is_store = 1'b0;
    funct3   = 3'b010;
    addr     = 32'h0000_5000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    is_load  = 1'b0;
    @(posedge clk); #1;
    check("rstbusy_read", 32'(dmem_read), 32'd0);
    check("rstbusy_stall", 32'(stall), 32'd0);
    check("rstbusy_address", dmem_address, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    #1;
    check("late_resp_lv", 32'(load_valid), 32'd0);
    check("late_resp_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    // Fresh lw after reset
    exp_req_q.push_back('{1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'b1111, 1'b0});
    exp_resp_q.push_back('{1'b1, 1'b0, 32'h1234_5678, 1'b1});
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, 32'h1234_5678, 1'b1);

    // is_load and is_store together act as a store
    clr_cnt();
    exp_req_q.push_back('{1'b0, 1'b1, 32'h0000_9000, 32'h1122_3344, 4'b1111, 1'b1});
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_9000, 32'h1122_3344, 0, 32'h0, 1'b1);
    check("both_read_cycles", read_cnt, 32'd0);
    check("both_lv_cycles", lv_cnt, 32'd0);

    // Back-to-back sw then lw, zero-wait memory
    clr_cnt();
    exp_req_q.push_back('{1'b0, 1'b1, 32'h0000_7004, 32'hCAFE_F00D, 4'b1111, 1'b1});
    exp_req_q.push_back('{1'b1, 1'b0, 32'h0000_7004, 32'h0, 4'b1111, 1'b0});
    exp_resp_q.push_back('{1'b1, 1'b0, 32'h0BAD_BEEF, 1'b1});
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_7004, 32'hCAFE_F00D, 0, 32'h0, 1'b1);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_7004, 32'h0, 0, 32'h0BAD_BEEF, 1'b1);
    check("b2b_read_cycles", read_cnt, 32'd1);
    check("b2b_write_cycles", write_cnt, 32'd1);
    check("b2b_lv_cycles", lv_cnt, 32'd1);
    check("b2b_stall_cycles", stall_cnt, 32'd4);

    repeat (3) @(posedge clk);
    #1;
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("resp_queue_drained", 32'(exp_resp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
